// File: rtl/sort3.sv
// sort3: registered three-input sorter with one-cycle latency.
// Samples d1_i/d2_i/d3_i on every rising clk edge with in_valid high and
// presents them reordered as max_o, med_o and min_o after that edge.
// Optional build macro SORT3_SIGNED_EN switches every compare from unsigned
// to two's-complement signed; ports, latency, reset and valid handling are
// the same in both builds.
module sort3 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] d1_i,
  input  logic [DATA_W-1:0] d2_i,
  input  logic [DATA_W-1:0] d3_i,
  output logic              out_valid,
  output logic [DATA_W-1:0] max_o,
  output logic [DATA_W-1:0] med_o,
  output logic [DATA_W-1:0] min_o
);

  // Strict greater-than in the build's number system. Only compare/select is
  // done anywhere, so the full range 0 .. 2^DATA_W-1 cannot overflow.
  function automatic logic gt(input logic [DATA_W-1:0] a,
                              input logic [DATA_W-1:0] b);
`ifdef SORT3_SIGNED_EN
    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    sa = signed'(a);
    sb = signed'(b);
    return sa > sb;
`else
    return a > b;
`endif
  endfunction

  // Ordering used below: for indices i<j, sample i ranks above sample j when
  // gt(di, dj); on a tie the higher index ranks above. That is a total order
  // on (value, index), so exactly one sample is picked for each slot and the
  // output multiset always equals the input multiset.
  function automatic logic [DATA_W-1:0] sel_max(input logic b12,
                                                input logic b13,
                                                input logic b23,
                                                input logic [DATA_W-1:0] a1,
                                                input logic [DATA_W-1:0] a2,
                                                input logic [DATA_W-1:0] a3);
    if (b12 && b13)       return a1;
    else if (!b12 && b23) return a2;
    else                  return a3;
  endfunction

  function automatic logic [DATA_W-1:0] sel_min(input logic b12,
                                                input logic b13,
                                                input logic b23,
                                                input logic [DATA_W-1:0] a1,
                                                input logic [DATA_W-1:0] a2,
                                                input logic [DATA_W-1:0] a3);
    if (!b12 && !b13)     return a1;
    else if (b12 && !b23) return a2;
    else                  return a3;
  endfunction

  // The median is the sample that ranks above exactly one of the other two.
  function automatic logic [DATA_W-1:0] sel_med(input logic b12,
                                                input logic b13,
                                                input logic b23,
                                                input logic [DATA_W-1:0] a1,
                                                input logic [DATA_W-1:0] a2,
                                                input logic [DATA_W-1:0] a3);
    if (b12 != b13)       return a1;
    else if (b12 == b23)  return a2;
    else                  return a3;
  endfunction

  // ---- Stage p0: pairwise compares and selection (combinational) ----
  logic              b12_p0;
  logic              b13_p0;
  logic              b23_p0;
  logic [DATA_W-1:0] max_p0;
  logic [DATA_W-1:0] med_p0;
  logic [DATA_W-1:0] min_p0;

  // Three compares feed all three selectors.
  always_comb begin
    b12_p0 = gt(d1_i, d2_i);
    b13_p0 = gt(d1_i, d3_i);
    b23_p0 = gt(d2_i, d3_i);
    max_p0 = sel_max(b12_p0, b13_p0, b23_p0, d1_i, d2_i, d3_i);
    med_p0 = sel_med(b12_p0, b13_p0, b23_p0, d1_i, d2_i, d3_i);
    min_p0 = sel_min(b12_p0, b13_p0, b23_p0, d1_i, d2_i, d3_i);
  end

  // ---- Stage p1: output registers ----
  logic              vld_p1;
  logic [DATA_W-1:0] max_p1;
  logic [DATA_W-1:0] med_p1;
  logic [DATA_W-1:0] min_p1;

  // Valid flag follows in_valid every edge; reset drops it at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= in_valid;
  end

  // Sorted data loads only on a valid triple and otherwise holds; reset
  // clears it so a pending result is discarded and nothing is ever X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_p1 <= '0;
      med_p1 <= '0;
      min_p1 <= '0;
    end else if (in_valid) begin
      max_p1 <= max_p0;
      med_p1 <= med_p0;
      min_p1 <= min_p0;
    end
  end

  assign out_valid = vld_p1;
  assign max_o     = max_p1;
  assign med_o     = med_p1;
  assign min_o     = min_p1;

endmodule

// File: tb/tb_sort3.sv
// Directed testbench for sort3: reset, ascending stream and hold, all
// permutations, ties/extremes, asynchronous mid-stream reset and the
// signed/unsigned ordering difference (macro SORT3_SIGNED_EN).
module tb_sort3;
  localparam int DATA_W = 8;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] d1_i;
  logic [DATA_W-1:0] d2_i;
  logic [DATA_W-1:0] d3_i;
  logic              out_valid;
  logic [DATA_W-1:0] max_o;
  logic [DATA_W-1:0] med_o;
  logic [DATA_W-1:0] min_o;

  int n_checks = 0;
  int n_fails  = 0;

  sort3 #(.DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .d1_i     (d1_i),
    .d2_i     (d2_i),
    .d3_i     (d3_i),
    .out_valid(out_valid),
    .max_o    (max_o),
    .med_o    (med_o),
    .min_o    (min_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply a triple, clock it in and settle 1 time unit past the edge.
  task automatic apply(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c);
    in_valid = v;
    d1_i = a;
    d2_i = b;
    d3_i = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b1;
    d1_i = 8'd50; d2_i = 8'd60; d3_i = 8'd70;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, max_o, med_o, min_o} !== 25'd0) begin
      n_fails++;
      $display("FAIL reset_hold: got v=%b %0d/%0d/%0d want v=0 0/0/0",
               out_valid, max_o, med_o, min_o);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_ascending;
    logic [7:0] ins [3][3];
    logic [7:0] exp [3][3];
    ins = '{'{8'd1, 8'd2, 8'd3}, '{8'd4, 8'd6, 8'd8}, '{8'd11, 8'd13, 8'd15}};
    exp = '{'{8'd3, 8'd2, 8'd1}, '{8'd8, 8'd6, 8'd4}, '{8'd15, 8'd13, 8'd11}};
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, ins[i][0], ins[i][1], ins[i][2]);
      n_checks++;
      if ({out_valid, max_o, med_o, min_o} !== {1'b1, exp[i][0], exp[i][1], exp[i][2]}) begin
        n_fails++;
        $display("FAIL ascending[%0d]: got v=%b %0d/%0d/%0d want v=1 %0d/%0d/%0d",
                 i, out_valid, max_o, med_o, min_o, exp[i][0], exp[i][1], exp[i][2]);
      end
    end
    for (int i = 0; i < 20; i++) begin
      apply(1'b0, 8'(i * 7 + 90), 8'(i), 8'(255 - i));
      n_checks++;
      if ({out_valid, max_o, med_o, min_o} !== {1'b0, 8'd15, 8'd13, 8'd11}) begin
        n_fails++;
        $display("FAIL idle_hold[%0d]: got v=%b %0d/%0d/%0d want v=0 15/13/11",
                 i, out_valid, max_o, med_o, min_o);
      end
    end
  endtask

  task automatic test_permutations;
    logic [7:0] p [6][3];
    p = '{'{8'd5, 8'd9, 8'd200}, '{8'd5, 8'd200, 8'd9}, '{8'd9, 8'd5, 8'd200},
          '{8'd9, 8'd200, 8'd5}, '{8'd200, 8'd5, 8'd9}, '{8'd200, 8'd9, 8'd5}};
    for (int i = 0; i < 6; i++) begin
      apply(1'b1, p[i][0], p[i][1], p[i][2]);
      n_checks++;
      if ({out_valid, max_o, med_o, min_o} !== {1'b1, 8'd200, 8'd9, 8'd5}) begin
        n_fails++;
        $display("FAIL perm[%0d]: got v=%b %0d/%0d/%0d want v=1 200/9/5",
                 i, out_valid, max_o, med_o, min_o);
      end
    end
  endtask

  task automatic test_ties_extremes;
    logic [7:0] ins [6][3];
    logic [7:0] exp [6][3];
    ins = '{'{8'd7, 8'd7, 8'd2}, '{8'd2, 8'd7, 8'd7}, '{8'd42, 8'd42, 8'd42},
            '{8'd255, 8'd0, 8'd128}, '{8'd0, 8'd0, 8'd0}, '{8'd7, 8'd2, 8'd2}};
    exp = '{'{8'd7, 8'd7, 8'd2}, '{8'd7, 8'd7, 8'd2}, '{8'd42, 8'd42, 8'd42},
            '{8'd255, 8'd128, 8'd0}, '{8'd0, 8'd0, 8'd0}, '{8'd7, 8'd2, 8'd2}};
    for (int i = 0; i < 6; i++) begin
      apply(1'b1, ins[i][0], ins[i][1], ins[i][2]);
      n_checks++;
      if ({out_valid, max_o, med_o, min_o} !== {1'b1, exp[i][0], exp[i][1], exp[i][2]}) begin
        n_fails++;
        $display("FAIL ties[%0d]: got v=%b %0d/%0d/%0d want v=1 %0d/%0d/%0d",
                 i, out_valid, max_o, med_o, min_o, exp[i][0], exp[i][1], exp[i][2]);
      end
    end
  endtask

  task automatic test_async_reset;
    apply(1'b1, 8'd10, 8'd30, 8'd20);
    n_checks++;
    if ({out_valid, max_o, med_o, min_o} !== {1'b1, 8'd30, 8'd20, 8'd10}) begin
      n_fails++;
      $display("FAIL pre_reset: got v=%b %0d/%0d/%0d want v=1 30/20/10",
               out_valid, max_o, med_o, min_o);
    end
    // keep a pending triple on the inputs, then reset between edges
    d1_i = 8'd99; d2_i = 8'd77; d3_i = 8'd88;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, max_o, med_o, min_o} !== 25'd0) begin
      n_fails++;
      $display("FAIL async_clear: got v=%b %0d/%0d/%0d want v=0 0/0/0",
               out_valid, max_o, med_o, min_o);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, max_o, med_o, min_o} !== 25'd0) begin
      n_fails++;
      $display("FAIL reset_discard: got v=%b %0d/%0d/%0d want v=0 0/0/0",
               out_valid, max_o, med_o, min_o);
    end
    @(negedge clk);
    rst = 1'b0;
    apply(1'b1, 8'd3, 8'd1, 8'd2);
    n_checks++;
    if ({out_valid, max_o, med_o, min_o} !== {1'b1, 8'd3, 8'd2, 8'd1}) begin
      n_fails++;
      $display("FAIL post_reset: got v=%b %0d/%0d/%0d want v=1 3/2/1",
               out_valid, max_o, med_o, min_o);
    end
  endtask

  task automatic test_signedness;
    logic [7:0] emax, emed, emin;
`ifdef SORT3_SIGNED_EN
    emax = 8'h01; emed = 8'hFF; emin = 8'h80;
`else
    emax = 8'hFF; emed = 8'h80; emin = 8'h01;
`endif
    apply(1'b1, 8'hFF, 8'h01, 8'h80);
    n_checks++;
    if ({out_valid, max_o, med_o, min_o} !== {1'b1, emax, emed, emin}) begin
      n_fails++;
      $display("FAIL signedness: got v=%b %h/%h/%h want v=1 %h/%h/%h",
               out_valid, max_o, med_o, min_o, emax, emed, emin);
    end
    apply(1'b0, 8'h00, 8'h00, 8'h00);
    n_checks++;
    if ({out_valid, max_o, med_o, min_o} !== {1'b0, emax, emed, emin}) begin
      n_fails++;
      $display("FAIL final_hold: got v=%b %h/%h/%h want v=0 %h/%h/%h",
               out_valid, max_o, med_o, min_o, emax, emed, emin);
    end
  endtask

  initial begin
    in_valid = 1'b0;
    d1_i = '0; d2_i = '0; d3_i = '0;
    rst = 1'b1;
    test_reset();
    test_ascending();
    test_permutations();
    test_ties_extremes();
    test_async_reset();
    test_signedness();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/sort3.md
Name:
sort3

Overview:
- Registered three-input sorter: samples three unsigned words each clock and presents them reordered as maximum, median and minimum.
- Used as the ordering core of the median filter datapath; a row/column window feeds three samples per cycle, and downstream median stages consume med_o, max_o and min_o.
- Single clock domain, one-cycle latency, fully pipelined: one new triple accepted every cycle.

Parameters:
- DATA_W, 8, width of each input sample and each output.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, qualifies d1_i/d2_i/d3_i this cycle.
- d1_i, input, DATA_W, sample 1.
- d2_i, input, DATA_W, sample 2.
- d3_i, input, DATA_W, sample 3.
- out_valid, output, 1, max_o/med_o/min_o hold a result sorted from a valid triple.
- max_o, output, DATA_W, largest of the sampled triple.
- med_o, output, DATA_W, middle of the sampled triple.
- min_o, output, DATA_W, smallest of the sampled triple.

Behaviour:
- Reset
  - rst high asynchronously clears max_o, med_o, min_o and out_valid to 0, independent of clk.
  - While rst is held, outputs stay 0.
  - The first capture happens at the first rising edge with rst low.
- Comparison
  - Three pairwise magnitude compares (d1 vs d2, d1 vs d3, d2 vs d3), unsigned by default.
  - Selection logic is combinational; results go straight into the output registers.
  - No intermediate pipeline stage.
- Latency
  - Triple presented with in_valid=1 before rising edge N appears on the outputs after edge N, with out_valid=1 after that edge.
- in_valid=0 at an edge
  - max_o/med_o/min_o hold their previous values.
  - out_valid is cleared to 0 at that edge.
- Back-to-back valid triples produce back-to-back results; throughput is 1 triple/cycle.
- Ties: equal inputs are legal. Each output value is correct and deterministic. With all three equal, all outputs equal that value.
- Output invariant: the output multiset always equals the input multiset. Each output always satisfies min_o <= med_o <= max_o.
- Full range: 0 and 2^DATA_W-1 are handled with no overflow. No arithmetic is performed, only compare/select.
- Reset mid-stream: an asserted rst overrides any in-flight result. Outputs return to 0 immediately, and the pending triple is discarded.
- No X propagation: every output register is always reset or loaded from a defined select.

Optional Feature:
- Macro SORT3_SIGNED_EN.
- Defined: all compares treat inputs as two's-complement signed DATA_W values, and outputs are ordered by signed magnitude.
- Undefined: compares are unsigned.
- Port list, latency, reset and valid behaviour are identical in both builds.

Test Plan:
- Reset then ascending triples: rst high, then low. Drive in_valid=1 with (1,2,3), (4,6,8), (11,13,15) on consecutive cycles. Required: one cycle later each gives max/med/min = 3/2/1, then 8/6/4, then 15/13/11, with out_valid=1 each cycle. Then in_valid=0 for 20 cycles: outputs hold 15/13/11 and out_valid=0.
- Permutations: drive all six orderings of (5,9,200). Every one gives max/med/min = 200/9/5 one cycle later.
- Ties and extremes:
  - (7,7,2) -> 7/7/2.
  - (2,7,7) -> 7/7/2.
  - (42,42,42) -> 42/42/42.
  - (255,0,128) -> 255/128/0.
  - (0,0,0) -> 0/0/0.
- Asynchronous reset mid-stream: while results are streaming, assert rst between clock edges. Outputs and out_valid go to 0 before the next edge. After deassert, the next valid triple (3,1,2) gives 3/2/1 one cycle later.
- Signed build (SORT3_SIGNED_EN): (0xFF,0x01,0x80) -> max 0x01, med 0xFF, min 0x80. The same stimulus in the unsigned build -> 0xFF/0x80/0x01.
